// File: rtl/unit_b_ctrl_pkg.sv
// Shared definitions for the unitB sequencer: state encoding and derived-width helpers.
// Also used by the top-level unit generator to size its own buses consistently.
package unit_b_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOAD_TAIL,
    ST_PIX,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // A width of at least one bit keeps degenerate sizes (1 filter, 1 depth) legal.
  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/unit_b_ctrl_delay_line.sv
// Parameterised DEPTH x WIDTH shift register with one intermediate tap and the final stage.
module ctrl_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1,
  parameter int TAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] tap_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Stage k holds the input from k+1 cycles ago.
  assign tap_o  = stage_q[TAP-1];
  assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/unit_b_ctrl.sv
// Layer-pass sequencer for one unitB convolution unit: weight streaming, window firing
// and the accumulate / write-back strobes aligned with the unit's pipeline.
module unit_b_ctrl
  import unit_b_ctrl_pkg::*;
#(
  parameter int IFM_DEPTH         = 6,
  parameter int KERNAL_SIZE       = 5,
  parameter int NUMBER_OF_FILTERS = 16,
  parameter int NUMBER_OF_UNITS   = 1,
  parameter int OFM_SIZE          = 10,
  parameter int CONV_LATENCY      = 6,
  parameter int CEIL_FILTERS      = ceil_div(NUMBER_OF_FILTERS, NUMBER_OF_UNITS),
  parameter int ADDRESS_SIZE_WM   = safe_clog2(KERNAL_SIZE * KERNAL_SIZE * IFM_DEPTH * CEIL_FILTERS),
  parameter int OFM_ADDR_W        = safe_clog2(OFM_SIZE * OFM_SIZE)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 wm_enable_read,
  output logic [ADDRESS_SIZE_WM-1:0]           wm_address,
  output logic                                 wm_fifo_enable,
  input  logic                                 win_valid,
  output logic                                 win_ready,
  output logic                                 conv_enable,
  output logic                                 accu_enable,
  output logic                                 relu_enable,
  output logic                                 use_bias,
  output logic                                 ofm_we,
  output logic [OFM_ADDR_W-1:0]                ofm_address,
  output logic [safe_clog2(CEIL_FILTERS)-1:0]  filter_idx
);

  localparam int TAPS    = KERNAL_SIZE * KERNAL_SIZE;
  localparam int TAP_W   = safe_clog2(TAPS);
  localparam int DEPTH_W = safe_clog2(IFM_DEPTH);
  localparam int FILT_W  = safe_clog2(CEIL_FILTERS);
  localparam int DRAIN_W = safe_clog2(CONV_LATENCY + 2);

  localparam logic [TAP_W-1:0]      LAST_TAP    = TAP_W'(TAPS - 1);
  localparam logic [DEPTH_W-1:0]    LAST_DEPTH  = DEPTH_W'(IFM_DEPTH - 1);
  localparam logic [FILT_W-1:0]     LAST_FILTER = FILT_W'(CEIL_FILTERS - 1);
  localparam logic [OFM_ADDR_W-1:0] LAST_PIX    = OFM_ADDR_W'(OFM_SIZE * OFM_SIZE - 1);
  localparam logic [DRAIN_W-1:0]    LAST_DRAIN  = DRAIN_W'(CONV_LATENCY + 1);

  ctrl_state_e                state_q, state_d;
  logic [FILT_W-1:0]          filter_q, filter_d;
  logic [DEPTH_W-1:0]         depth_q, depth_d;
  logic [OFM_ADDR_W-1:0]      pix_q, pix_d;
  logic [TAP_W-1:0]           tap_q, tap_d;
  logic [DRAIN_W-1:0]         drain_q, drain_d;
  logic [ADDRESS_SIZE_WM-1:0] addr_q, addr_d;
  logic                       fifo_q;
  logic                       fire;

  logic [2:0]            flag_in, flag_tap, flag_last;
  logic [OFM_ADDR_W-1:0] pix_tap, pix_last;

  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign wm_enable_read = (state_q == ST_LOAD);
  assign wm_address     = addr_q;
  assign wm_fifo_enable = fifo_q;
  assign win_ready      = (state_q == ST_PIX);
  assign fire           = win_ready & win_valid;
  assign conv_enable    = fire;
  assign filter_idx     = filter_q;

  // Next state and counters; wm_address keeps counting across depths and filters.
  always_comb begin
    state_d  = state_q;
    filter_d = filter_q;
    depth_d  = depth_q;
    pix_d    = pix_q;
    tap_d    = tap_q;
    drain_d  = drain_q;
    addr_d   = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD;
          filter_d = '0;
          depth_d  = '0;
          pix_d    = '0;
          tap_d    = '0;
          drain_d  = '0;
          addr_d   = '0;
        end
      end
      ST_LOAD: begin
        addr_d = addr_q + ADDRESS_SIZE_WM'(1);
        if (tap_q == LAST_TAP) begin
          tap_d   = '0;
          state_d = ST_LOAD_TAIL;
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end
      ST_LOAD_TAIL: state_d = ST_PIX;
      ST_PIX: begin
        if (fire) begin
          if (pix_q == LAST_PIX) begin
            pix_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            pix_d = pix_q + OFM_ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          drain_d = '0;
          if (depth_q != LAST_DEPTH) begin
            depth_d = depth_q + DEPTH_W'(1);
            state_d = ST_LOAD;
          end else if (filter_q != LAST_FILTER) begin
            filter_d = filter_q + FILT_W'(1);
            depth_d  = '0;
            state_d  = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      filter_q <= '0;
      depth_q  <= '0;
      pix_q    <= '0;
      tap_q    <= '0;
      drain_q  <= '0;
      addr_q   <= '0;
      fifo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      filter_q <= filter_d;
      depth_q  <= depth_d;
      pix_q    <= pix_d;
      tap_q    <= tap_d;
      drain_q  <= drain_d;
      addr_q   <= addr_d;
      fifo_q   <= wm_enable_read;
    end
  end

  // Flags ride with each fire so a pixel keeps the depth it was fired under.
  assign flag_in = {depth_q == LAST_DEPTH, depth_q == '0, fire};

  ctrl_delay_line #(
    .DEPTH(CONV_LATENCY + 1),
    .WIDTH(3),
    .TAP  (CONV_LATENCY)
  ) u_flag_line (
    .clk   (clk),
    .reset (reset),
    .data_i(flag_in),
    .tap_o (flag_tap),
    .data_o(flag_last)
  );

  ctrl_delay_line #(
    .DEPTH(CONV_LATENCY + 1),
    .WIDTH(OFM_ADDR_W),
    .TAP  (CONV_LATENCY)
  ) u_pix_line (
    .clk   (clk),
    .reset (reset),
    .data_i(pix_q),
    .tap_o (pix_tap),
    .data_o(pix_last)
  );

  // Bias select and ReLU are held across both the accumulate and the write cycle of a pixel;
  // the write address wins when a write and the next pixel's partial-sum read coincide.
  assign accu_enable = flag_tap[0];
  assign ofm_we      = flag_last[0];
  assign use_bias    = (flag_tap[0] & flag_tap[1]) | (flag_last[0] & flag_last[1]);
  assign relu_enable = (flag_tap[0] & flag_tap[2]) | (flag_last[0] & flag_last[2]);
  assign ofm_address = ofm_we ? pix_last : (accu_enable ? pix_tap : '0);

endmodule

// File: tb/tb_unit_b_ctrl.sv
// Scoreboard bench for unit_b_ctrl: the stimulus side queues the expected read addresses and
// pixel events of a whole layer pass; a negedge monitor pops and compares as the DUT emits strobes.
module tb_unit_b_ctrl;

  localparam int IFM_DEPTH   = 2;
  localparam int NF          = 2;
  localparam int NU          = 1;
  localparam int OFM_SIZE    = 2;
  localparam int CL          = 3;
  localparam int TAPS        = 25;
  localparam int NPIX        = OFM_SIZE * OFM_SIZE;
  localparam int WM_W        = 7;
  localparam int OFM_W       = 2;
  localparam int PASS_CYCLES = NF * IFM_DEPTH * (TAPS + 1 + NPIX + CL + 2) + 1;
  localparam int BUDGET      = 5000;

  typedef struct {
    int pix;
    int bias;
    int relu;
    int filt;
    int fireCyc;
  } pixEvt_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             winValid = 1'b0;
  logic             busy, done, wmEnableRead, wmFifoEnable, winReady;
  logic             convEnable, accuEnable, reluEnable, useBias, ofmWe;
  logic [WM_W-1:0]  wmAddress;
  logic [OFM_W-1:0] ofmAddress;
  logic [0:0]       filterIdx;

  int      expRdQ[$];
  pixEvt_t expPixQ[$];
  pixEvt_t accuPendQ[$];
  pixEvt_t wePendQ[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int passBusy = 0;
  int lastPassCycles = 0;
  int fifoCnt = 0;
  int fireCnt = 0;
  int doneCnt = 0;
  int mode = 0;
  int patIdx = 0;
  bit passActive = 1'b0;
  bit prevRead = 1'b0;
  bit checkBusyNext = 1'b0;
  bit pattern[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  unit_b_ctrl #(
    .IFM_DEPTH        (IFM_DEPTH),
    .KERNAL_SIZE      (5),
    .NUMBER_OF_FILTERS(NF),
    .NUMBER_OF_UNITS  (NU),
    .OFM_SIZE         (OFM_SIZE),
    .CONV_LATENCY     (CL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .wm_enable_read(wmEnableRead),
    .wm_address    (wmAddress),
    .wm_fifo_enable(wmFifoEnable),
    .win_valid     (winValid),
    .win_ready     (winReady),
    .conv_enable   (convEnable),
    .accu_enable   (accuEnable),
    .relu_enable   (reluEnable),
    .use_bias      (useBias),
    .ofm_we        (ofmWe),
    .ofm_address   (ofmAddress),
    .filter_idx    (filterIdx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_wm_enable_read", wmEnableRead, 0);
    checkOutput("rst_wm_address", wmAddress, 0);
    checkOutput("rst_wm_fifo_enable", wmFifoEnable, 0);
    checkOutput("rst_win_ready", winReady, 0);
    checkOutput("rst_conv_enable", convEnable, 0);
    checkOutput("rst_accu_enable", accuEnable, 0);
    checkOutput("rst_relu_enable", reluEnable, 0);
    checkOutput("rst_use_bias", useBias, 0);
    checkOutput("rst_ofm_we", ofmWe, 0);
    checkOutput("rst_ofm_address", ofmAddress, 0);
    checkOutput("rst_filter_idx", filterIdx, 0);
  endtask

  // Reference for one layer pass: every weight address in order and every pixel event.
  task automatic pushPass();
    for (int f = 0; f < NF; f++) begin
      for (int d = 0; d < IFM_DEPTH; d++) begin
        for (int t = 0; t < TAPS; t++) expRdQ.push_back(f * TAPS * IFM_DEPTH + d * TAPS + t);
        for (int p = 0; p < NPIX; p++) begin
          pixEvt_t e;
          e.pix = p;
          e.bias = (d == 0) ? 1 : 0;
          e.relu = (d == IFM_DEPTH - 1) ? 1 : 0;
          e.filt = f;
          e.fireCyc = 0;
          expPixQ.push_back(e);
        end
      end
    end
    passActive = 1'b1;
  endtask

  // Called at posedge+1 of a cycle in which the DUT is idle; returns at posedge+1 of the
  // cycle after done, so a following call starts back-to-back.
  task automatic applyStimulus(input int validMode, input bit extraStarts, input bit checkCycles);
    bit got;
    pushPass();
    mode = validMode;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 1'b0;
    for (int n = 0; n < BUDGET && !got; n++) begin
      @(negedge clk);
      start = (extraStarts && (n == 30 || n == 100)) ? 1'b1 : 1'b0;
      if (done) got = 1'b1;
    end
    if (!got) begin
      checkOutput("done_timeout", 0, 1);
      passActive = 1'b0;
    end
    @(posedge clk);
    #1 start = 1'b0;
    if (got && checkCycles) checkOutput("pass_cycles", lastPassCycles, PASS_CYCLES);
  endtask

  // Window-valid source: all ones, random, or the fixed toggle pattern stepped per PIX cycle.
  always @(posedge clk) begin
    #1;
    case (mode)
      0: winValid = 1'b1;
      1: winValid = ($urandom_range(0, 3) != 0);
      default: begin
        winValid = pattern[patIdx];
        if (winReady) patIdx = (patIdx + 1) % 7;
      end
    endcase
  end

  // Monitor: pops expectations as the DUT presents reads, fires, accumulates and writes.
  always @(negedge clk) begin
    pixEvt_t a;
    pixEvt_t w;
    int eb;
    int er;
    if (reset) begin
      accuPendQ.delete();
      wePendQ.delete();
      prevRead = 1'b0;
      passBusy = 0;
      fifoCnt = 0;
      fireCnt = 0;
      checkBusyNext = 1'b0;
    end else begin
      cyc++;
      if (busy) passBusy++;
      if (wmEnableRead) begin
        if (expRdQ.size() == 0) checkOutput("read_unexpected", 1, 0);
        else checkOutput("wm_address", wmAddress, expRdQ.pop_front());
      end
      if (wmFifoEnable) begin
        fifoCnt++;
        checkOutput("fifo_after_read", prevRead, 1);
      end
      prevRead = wmEnableRead;
      eb = 0;
      er = 0;
      if (ofmWe) begin
        if (wePendQ.size() == 0) checkOutput("we_unexpected", 1, 0);
        else begin
          w = wePendQ.pop_front();
          checkOutput("we_latency", cyc - w.fireCyc, CL + 1);
          checkOutput("ofm_address_we", ofmAddress, w.pix);
          checkOutput("filter_idx_we", filterIdx, w.filt);
          eb |= w.bias;
          er |= w.relu;
        end
      end
      if (accuEnable) begin
        if (accuPendQ.size() == 0) checkOutput("accu_unexpected", 1, 0);
        else begin
          a = accuPendQ.pop_front();
          checkOutput("accu_latency", cyc - a.fireCyc, CL);
          if (!ofmWe) checkOutput("ofm_address_rd", ofmAddress, a.pix);
          eb |= a.bias;
          er |= a.relu;
          wePendQ.push_back(a);
        end
      end
      checkOutput("use_bias", useBias, eb);
      checkOutput("relu_enable", reluEnable, er);
      if (convEnable) begin
        fireCnt++;
        checkOutput("conv_needs_valid", winValid, 1);
        if (expPixQ.size() == 0) checkOutput("conv_unexpected", 1, 0);
        else begin
          a = expPixQ.pop_front();
          a.fireCyc = cyc;
          accuPendQ.push_back(a);
        end
      end
      if (done) begin
        checkOutput("done_expected", passActive, 1);
        checkOutput("filter_idx_end", filterIdx, NF - 1);
        checkOutput("busy_at_done", busy, 1);
        checkOutput("reads_left", expRdQ.size(), 0);
        checkOutput("pixels_left", expPixQ.size() + accuPendQ.size() + wePendQ.size(), 0);
        checkOutput("fifo_pulses", fifoCnt, NF * IFM_DEPTH * TAPS);
        checkOutput("conv_fires", fireCnt, NF * IFM_DEPTH * NPIX);
        lastPassCycles = passBusy;
        passBusy = 0;
        fifoCnt = 0;
        fireCnt = 0;
        passActive = 1'b0;
        doneCnt++;
        checkBusyNext = 1'b1;
      end else if (checkBusyNext) begin
        checkOutput("busy_after_done", busy, 0);
        checkBusyNext = 1'b0;
      end
    end
  end

  initial begin
    bit found;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkResetOutputs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    $display("[TB] pass 1: win_valid held high");
    applyStimulus(0, 1'b0, 1'b1);
    $display("[TB] pass 2: back-to-back start");
    applyStimulus(0, 1'b0, 1'b1);
    $display("[TB] pass 3: toggled win_valid with start re-pulsed mid-pass");
    applyStimulus(2, 1'b1, 1'b0);
    $display("[TB] pass 4: random win_valid with start re-pulsed mid-pass");
    applyStimulus(1, 1'b1, 1'b0);

    $display("[TB] pass 5: reset during the second load phase");
    pushPass();
    mode = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < BUDGET && !found; n++) begin
      @(negedge clk);
      #2;
      if (wmEnableRead && wmAddress == WM_W'(30)) found = 1'b1;
    end
    if (!found) checkOutput("addr30_timeout", 0, 1);
    reset = 1'b1;
    #1 checkResetOutputs();
    passActive = 1'b0;
    expRdQ.delete();
    expPixQ.delete();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    $display("[TB] pass 6: restart after reset");
    applyStimulus(0, 1'b0, 1'b1);

    checkOutput("done_count", doneCnt, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
